// File: rtl/button_debounce_counter_pkg.sv
// Shared types and constants for the pushbutton debounce / press-counter block.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    DEB_RELEASE = 2'd3
  } deb_state_t;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 50000;
  localparam int DEF_LONG_CYCLES   = 25000000;
  localparam int DEF_COUNT_W       = 8;

  // Short timings so simulations finish in a few thousand cycles.
  localparam int SIM_STABLE_CYCLES = 4;
  localparam int SIM_LONG_CYCLES   = 20;

endpackage

// File: rtl/button_debounce_counter_if.sv
// Signal bundle between the pushbutton block and its user logic.
interface button_debounce_counter_if #(
  parameter int COUNT_W = 8
) ();
  import btn_pkg::*;

  // No valid/ready: inputs are sampled every clock, outputs are registered
  // levels or single-cycle pulses that the consumer must catch when high.
  logic               i_btn_in;
  logic               i_clear_count;
  logic               o_btn_level;
  logic               o_press_pulse;
  logic               o_release_pulse;
  logic               o_long_pulse;
  logic [COUNT_W-1:0] o_press_count;
  deb_state_t         o_state;

  modport master (
    output i_btn_in, i_clear_count,
    input  o_btn_level, o_press_pulse, o_release_pulse, o_long_pulse,
           o_press_count, o_state
  );

  modport slave (
    input  i_btn_in, i_clear_count,
    output o_btn_level, o_press_pulse, o_release_pulse, o_long_pulse,
           o_press_count, o_state
  );

endinterface

// File: rtl/button_debounce_counter_sync.sv
// Multi-flop synchroniser for an asynchronous single-bit input; resets to 0.
module input_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[STAGES-2:0], d};
  end

  assign q = r_sync[STAGES-1];

endmodule

// File: rtl/button_debounce_counter.sv
// Debounces a raw pushbutton into a clean level, press/release/long-hold
// pulses and a wrapping press counter.
module button_debounce_counter
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int COUNT_W       = DEF_COUNT_W
) (
  input logic clk,
  input logic rst,
  button_debounce_counter_if.slave bus
);

  localparam int STABLE_W = $clog2(STABLE_CYCLES);
  localparam int HOLD_W   = $clog2(LONG_CYCLES);
  localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(STABLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(LONG_CYCLES - 1);

  logic               w_btn_sync;
  deb_state_t         r_state;
  deb_state_t         w_next_state;
  logic [STABLE_W-1:0] r_cnt;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic               r_long_done;
  logic               r_btn_level;
  logic               r_press_pulse;
  logic               r_release_pulse;
  logic               r_long_pulse;
  logic [COUNT_W-1:0] r_press_count;
  logic               w_cnt_done;
  logic               w_cnt_clear;
  logic               w_cnt_inc;
  logic               w_accept_press;
  logic               w_accept_release;
  logic               w_hold_active;

  input_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.i_btn_in),
    .q   (w_btn_sync)
  );

  assign w_cnt_done = (r_cnt == STABLE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:        if (w_btn_sync) w_next_state = DEB_PRESS;
      DEB_PRESS:   if (!w_btn_sync) w_next_state = IDLE;
                   else if (w_cnt_done) w_next_state = PRESSED;
      PRESSED:     if (!w_btn_sync) w_next_state = DEB_RELEASE;
      DEB_RELEASE: if (w_btn_sync) w_next_state = PRESSED;
                   else if (w_cnt_done) w_next_state = IDLE;
      default:     w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_cnt_clear      = 1'b0;
    w_cnt_inc        = 1'b0;
    w_accept_press   = 1'b0;
    w_accept_release = 1'b0;
    case (r_state)
      IDLE:        w_cnt_clear = w_btn_sync;
      DEB_PRESS:   if (w_btn_sync) begin
                     if (w_cnt_done) w_accept_press = 1'b1;
                     else            w_cnt_inc      = 1'b1;
                   end
      PRESSED:     w_cnt_clear = !w_btn_sync;
      DEB_RELEASE: if (!w_btn_sync) begin
                     if (w_cnt_done) w_accept_release = 1'b1;
                     else            w_cnt_inc        = 1'b1;
                   end
      default:     ;
    endcase
  end

  // A bounce back into PRESSED keeps the hold timer running.
  assign w_hold_active = ((r_state == PRESSED) || (r_state == DEB_RELEASE)) && !r_long_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt           <= '0;
      r_hold_cnt      <= '0;
      r_long_done     <= 1'b0;
      r_btn_level     <= 1'b0;
      r_press_pulse   <= 1'b0;
      r_release_pulse <= 1'b0;
      r_long_pulse    <= 1'b0;
      r_press_count   <= '0;
    end else begin
      r_press_pulse   <= w_accept_press;
      r_release_pulse <= w_accept_release;
      r_long_pulse    <= 1'b0;

      if (w_cnt_clear)    r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + STABLE_W'(1);

      if (w_accept_press)        r_btn_level <= 1'b1;
      else if (w_accept_release) r_btn_level <= 1'b0;

      if (w_accept_press) begin
        r_hold_cnt  <= '0;
        r_long_done <= 1'b0;
      end else if (w_hold_active) begin
        if (r_hold_cnt == HOLD_LAST) begin
          r_long_pulse <= 1'b1;
          r_long_done  <= 1'b1;
        end else begin
          r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
        end
      end

      // Clear takes effect before a coincident press is counted.
      if (w_accept_press)
        r_press_count <= (bus.i_clear_count ? '0 : r_press_count) + COUNT_W'(1);
      else if (bus.i_clear_count)
        r_press_count <= '0;
    end
  end

  assign bus.o_btn_level     = r_btn_level;
  assign bus.o_press_pulse   = r_press_pulse;
  assign bus.o_release_pulse = r_release_pulse;
  assign bus.o_long_pulse    = r_long_pulse;
  assign bus.o_press_count   = r_press_count;
  assign bus.o_state         = r_state;

endmodule

// File: tb/tb_button_debounce_counter.sv
// Self-checking bench for button_debounce_counter with the short simulation timings.
module tb_button_debounce_counter;
  import btn_pkg::*;

  localparam int SYNC   = 2;
  localparam int STABLE = SIM_STABLE_CYCLES;
  localparam int LONG   = SIM_LONG_CYCLES;
  localparam int CW     = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  button_debounce_counter_if #(.COUNT_W(CW)) bus ();

  button_debounce_counter #(
    .SYNC_STAGES  (SYNC),
    .STABLE_CYCLES(STABLE),
    .LONG_CYCLES  (LONG),
    .COUNT_W      (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int p_cnt, r_cnt, l_cnt, p_edge, l_edge;
  bit lvl_seen;
  logic prev_p, prev_r, prev_l;

  logic [CW-1:0] exp_q[$];

  function automatic void chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  // btn_in history reproduces the synchroniser delay; a level change is
  // accepted once the delayed input has disagreed with the debounced level
  // on STABLE+1 consecutive edges.
  logic          m_hist[$];
  int            m_run, m_age;
  bit            m_done;
  logic          m_level, m_press, m_release, m_long;
  logic [CW-1:0] m_count;

  function automatic void model_reset();
    m_hist = {};
    for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
    m_run = 0; m_age = 0; m_done = 0;
    m_level = 0; m_press = 0; m_release = 0; m_long = 0;
    m_count = '0;
    exp_q = {};
  endfunction

  function automatic void model_edge(input logic b, input logic c);
    logic s;
    s = m_hist[0];
    void'(m_hist.pop_front());
    m_hist.push_back(b);
    m_press = 0; m_release = 0; m_long = 0;
    if (c) m_count = '0;
    if (m_level && !m_done) begin
      m_age++;
      if (m_age == LONG) begin m_long = 1; m_done = 1; end
    end
    if (s != m_level) m_run++;
    else              m_run = 0;
    if (m_run == STABLE + 1) begin
      m_run   = 0;
      m_level = s;
      if (s) begin
        m_press = 1;
        m_count = m_count + 1'b1;
        m_age   = 0;
        m_done  = 0;
        exp_q.push_back(m_count);
      end else begin
        m_release = 1;
      end
    end
  endfunction

  function automatic void check_model();
    chk("m_level",   bus.o_btn_level,     m_level);
    chk("m_press",   bus.o_press_pulse,   m_press);
    chk("m_release", bus.o_release_pulse, m_release);
    chk("m_long",    bus.o_long_pulse,    m_long);
    chk("m_count",   bus.o_press_count,   m_count);
    if (bus.o_press_pulse) begin
      if (exp_q.size() == 0) chk("sb_press_unexpected", 1, 0);
      else                   chk("sb_press_count", bus.o_press_count, exp_q.pop_front());
    end
    chk("press_not_consec",   prev_p & bus.o_press_pulse,   0);
    chk("release_not_consec", prev_r & bus.o_release_pulse, 0);
    chk("long_not_consec",    prev_l & bus.o_long_pulse,    0);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input logic b, input logic c);
    bus.i_btn_in      = b;
    bus.i_clear_count = c;
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge(b, c);
    #1;
    cyc++;
    check_model();
    prev_p = bus.o_press_pulse;
    prev_r = bus.o_release_pulse;
    prev_l = bus.o_long_pulse;
    if (bus.o_press_pulse)   begin p_cnt++; p_edge = cyc; end
    if (bus.o_release_pulse) r_cnt++;
    if (bus.o_long_pulse)    begin l_cnt++; l_edge = cyc; end
    if (bus.o_btn_level)     lvl_seen = 1;
  endtask

  task automatic hold(input logic b, input int n);
    repeat (n) step(b, 1'b0);
  endtask

  task automatic clr_track();
    p_cnt = 0; r_cnt = 0; l_cnt = 0; p_edge = 0; l_edge = 0; lvl_seen = 0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    hold(1'b0, 2);
    #4;
    rst = 1'b0;
    clr_track();
  endtask

  task automatic one_press();
    hold(1'b1, 8);
    hold(1'b0, 8);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic          btn;
    logic          clr;
    logic          lvl;
    logic          prs;
    logic          rel;
    logic          lng;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t tbl[20];
  int   cyc0;

  initial begin
    // Row i is driven before edge i+1 after reset; press lands on edge 7,
    // release 7 edges after the fall at edge 11, clear on edge 19.
    for (int i = 0; i < 20; i++) begin
      tbl[i].btn = (i < 10);
      tbl[i].clr = (i == 18);
      tbl[i].lvl = (i >= 6 && i < 16);
      tbl[i].prs = (i == 6);
      tbl[i].rel = (i == 16);
      tbl[i].lng = 1'b0;
      tbl[i].cnt = (i >= 6 && i < 18) ? 8'd1 : 8'd0;
    end
    prev_p = 0; prev_r = 0; prev_l = 0;
    bus.i_btn_in = 0;
    bus.i_clear_count = 0;
    model_reset();

    // reset state
    apply_reset();
    chk("rst_level",   bus.o_btn_level,     0);
    chk("rst_press",   bus.o_press_pulse,   0);
    chk("rst_release", bus.o_release_pulse, 0);
    chk("rst_long",    bus.o_long_pulse,    0);
    chk("rst_count",   bus.o_press_count,   0);
    chk("rst_state",   int'(bus.o_state),   int'(IDLE));

    // clean press / release / clear table
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].btn, tbl[i].clr);
      chk($sformatf("tbl%0d_level", i),   bus.o_btn_level,     tbl[i].lvl);
      chk($sformatf("tbl%0d_press", i),   bus.o_press_pulse,   tbl[i].prs);
      chk($sformatf("tbl%0d_release", i), bus.o_release_pulse, tbl[i].rel);
      chk($sformatf("tbl%0d_long", i),    bus.o_long_pulse,    tbl[i].lng);
      chk($sformatf("tbl%0d_count", i),   bus.o_press_count,   tbl[i].cnt);
    end

    // bounce: 1,0,1,0 then final rise held
    apply_reset();
    hold(1'b1, 1); hold(1'b0, 1); hold(1'b1, 1); hold(1'b0, 1);
    cyc0 = cyc;
    hold(1'b1, 12);
    chk("bounce_press_once", p_cnt, 1);
    chk("bounce_press_edge", p_edge - cyc0, 7);
    chk("bounce_count",      bus.o_press_count, 1);

    // long hold
    apply_reset();
    hold(1'b1, 40);
    chk("long_once",        l_cnt, 1);
    chk("long_after_press", l_edge - p_edge, LONG);
    hold(1'b0, 12);
    clr_track();
    hold(1'b1, 14);
    hold(1'b0, 1);
    hold(1'b1, 30);
    chk("glitch_long_once",   l_cnt, 1);
    chk("glitch_long_timing", l_edge - p_edge, LONG);
    chk("glitch_no_release",  r_cnt, 0);
    hold(1'b0, 12);
    chk("glitch_release_after", r_cnt, 1);

    // wrap after 256 presses
    apply_reset();
    repeat (256) one_press();
    chk("wrap_presses", p_cnt, 256);
    chk("wrap_count",   bus.o_press_count, 0);

    // clear coincident with the 3rd press
    apply_reset();
    one_press();
    one_press();
    hold(1'b1, 6);
    step(1'b1, 1'b1);
    chk("clr_press_pulse", bus.o_press_pulse, 1);
    chk("clr_press_count", bus.o_press_count, 1);
    hold(1'b0, 8);

    // asynchronous reset in DEB_PRESS
    apply_reset();
    one_press();
    hold(1'b1, 4);
    chk("pre_rst_state", int'(bus.o_state), int'(DEB_PRESS));
    chk("pre_rst_count", bus.o_press_count, 1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst_count", bus.o_press_count, 0);
    chk("async_rst_state", int'(bus.o_state), int'(IDLE));
    chk("async_rst_level", bus.o_btn_level, 0);
    step(1'b1, 1'b0);
    #4;
    rst = 1'b0;
    clr_track();
    cyc0 = cyc;
    hold(1'b1, 9);
    chk("rst_repress_once", p_cnt, 1);
    chk("rst_repress_edge", p_edge - cyc0, 7);

    // short glitch from IDLE
    apply_reset();
    hold(1'b1, 3);
    hold(1'b0, 10);
    chk("idle_glitch_press", p_cnt, 0);
    chk("idle_glitch_level", lvl_seen, 0);

    // randomized segments against the model
    apply_reset();
    for (int seg = 0; seg < 200; seg++) begin
      logic b;
      int   n;
      b = 1'($urandom_range(0, 1));
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 30) : $urandom_range(1, 9);
      for (int k = 0; k < n; k++) step(b, $urandom_range(0, 29) == 0);
    end
    hold(1'b0, 10);
    chk("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
